prefix_add_seq_arb: RTL and testbench

- Two-requester controller that shares one SLICE-bit combinational prefix-adder slice.
- Sequences that slice over WIDTH/SLICE cycles to complete a full WIDTH-bit add with carry-in.
- Sits between two operand producers and one result consumer.
- Each side uses a valid/ready handshake; round-robin arbitration between requesters.

---
 rtl/prefix_add_seq_arb_if.sv | 40 ++++
 rtl/prefix_add_seq_arb.sv | 172 +++++++++++++++++
 tb/tb_prefix_add_seq_arb.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefix_add_seq_arb_if.sv
// Handshake bundle for prefix_add_seq_arb: two operand requesters and one
// result consumer. The adder sits on the slave side of this interface.
interface prefix_add_seq_arb_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_sum;
    logic             resp_cout;
    logic             resp_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout, resp_ovf
    );
endinterface

// File: rtl/prefix_add_seq_arb.sv
// Two-requester sequential adder. One SLICE-bit prefix-adder slice is reused
// for WIDTH/SLICE cycles to build a full WIDTH-bit sum with carry-in; the two
// requesters are served round-robin and the result is held until consumed.
module prefix_add_seq_arb #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    prefix_add_seq_arb_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_width_check
            $error("prefix_add_seq_arb: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic             last_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             id_q;
    logic             cout_q;
    logic             ovf_q;

    logic [1:0]       gnt;
    logic             accept;
    logic             last_k;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] ss;
    logic             sc;

    // Kogge-Stone style parallel-prefix add of one slice: builds group
    // generate/propagate over [i:0] in log2(SLICE) levels, then folds in cin.
    function automatic logic [SLICE:0] slice_add(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             cin
    );
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] gg;
        logic [SLICE-1:0] pg;
        logic [SLICE-1:0] gn;
        logic [SLICE-1:0] pn;
        logic [SLICE:0]   c;
        p  = x ^ y;
        gg = x & y;
        pg = p;
        for (int d = 1; d < SLICE; d = d * 2) begin
            gn = gg;
            pn = pg;
            for (int i = d; i < SLICE; i++) begin
                gn[i] = gg[i] | (pg[i] & gg[i-d]);
                pn[i] = pg[i] & pg[i-d];
            end
            gg = gn;
            pg = pn;
        end
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            c[i+1] = gg[i] | (pg[i] & cin);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    // Round-robin grant: a lone requester wins; on contention the one that
    // did not win last time goes first. No grant when nobody is asking.
    always_comb begin
        gnt = 2'b00;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt = {bus.req1_valid, bus.req0_valid};
        end
    end

    assign bus.req0_ready = (state_q == IDLE) && gnt[0];
    assign bus.req1_ready = (state_q == IDLE) && gnt[1];
    assign accept         = (state_q == IDLE) && (gnt != 2'b00);
    assign last_k         = (k_q == KW'(NSLICE - 1));

    assign sa        = a_q[SLICE*k_q +: SLICE];
    assign sb        = b_q[SLICE*k_q +: SLICE];
    assign {sc, ss}  = slice_add(sa, sb, carry_q);

    // Next-state logic: accept -> run NSLICE slices -> hold result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_k) state_d = DONE;
            DONE:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slice counter, inter-slice carry and last-grant pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            last_q  <= 1'b1;
        end else if (accept) begin
            k_q     <= '0;
            carry_q <= gnt[1] ? bus.req1_cin : bus.req0_cin;
            last_q  <= gnt[1];
        end else if (state_q == RUN) begin
            k_q     <= k_q + KW'(1);
            carry_q <= sc;
        end
    end

    // Operand capture; contents only matter while an operation is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= gnt[1] ? bus.req1_a : bus.req0_a;
            b_q <= gnt[1] ? bus.req1_b : bus.req0_b;
        end
    end

    // Result assembly: one slice of the sum per RUN cycle, flags on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            id_q   <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (accept) begin
                id_q <= gnt[1];
            end
            if (state_q == RUN) begin
                sum_q[SLICE*k_q +: SLICE] <= ss;
                if (last_k) begin
                    cout_q <= sc;
                    ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ss[SLICE-1] != a_q[WIDTH-1]);
                end
            end
        end
    end

    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.resp_cout  = cout_q;
    assign bus.resp_ovf   = ovf_q;

endmodule

// File: tb/tb_prefix_add_seq_arb.sv
// Bench for prefix_add_seq_arb: directed cases plus randomized traffic,
// checked against a transaction-level reference model.
module tb_prefix_add_seq_arb;

    localparam int WIDTH = 32;
    localparam int SLICE = 4;
    localparam int LAT   = WIDTH / SLICE + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prefix_add_seq_arb_if #(.WIDTH(WIDTH)) bus ();

    prefix_add_seq_arb #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    // Reference: plain wide unsigned and signed arithmetic.
    function automatic exp_t ref_add(input logic id, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic cin);
        exp_t           e;
        logic [WIDTH:0] u;
        longint         sg;
        longint         lim;
        u      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sg     = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        lim    = 64'sd1 <<< (WIDTH - 1);
        e.id   = id;
        e.sum  = u[WIDTH-1:0];
        e.cout = u[WIDTH];
        e.ovf  = (sg >= lim) || (sg < -lim);
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Transaction model: one operation in flight, result due LAT cycles
    // after acceptance, round-robin pointer starting at requester 1.
    exp_t q[$];
    logic busy     = 1'b0;
    logic last     = 1'b1;
    logic chk_rst  = 1'b0;
    logic prev_vld = 1'b0;
    int   cyc      = 0;
    int   acc_cyc  = 0;

    always @(negedge clk) begin
        logic [1:0] eg;
        logic       ev;
        exp_t       e;
        cyc++;
        if (rst) begin
            busy     = 1'b0;
            last     = 1'b1;
            chk_rst  = 1'b1;
            prev_vld = 1'b0;
            q.delete();
        end else begin
            if (chk_rst) begin
                chk("rst_valid", 64'(bus.resp_valid), 64'd0);
                chk("rst_sum",   64'(bus.resp_sum),   64'd0);
                chk("rst_flags", 64'({bus.resp_id, bus.resp_cout, bus.resp_ovf}), 64'd0);
                chk_rst = 1'b0;
            end
            eg = 2'b00;
            if (!busy) begin
                if (bus.req0_valid && bus.req1_valid) eg = last ? 2'b01 : 2'b10;
                else eg = {bus.req1_valid, bus.req0_valid};
            end
            chk("ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(eg));
            ev = busy && ((cyc - acc_cyc) >= LAT);
            chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
            if (ev && q.size() > 0) begin
                if (!prev_vld) chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
                chk("sum",  64'(bus.resp_sum),  64'(q[0].sum));
                chk("cout", 64'(bus.resp_cout), 64'(q[0].cout));
                chk("ovf",  64'(bus.resp_ovf),  64'(q[0].ovf));
                chk("id",   64'(bus.resp_id),   64'(q[0].id));
            end
            prev_vld = bus.resp_valid;
            if (busy) begin
                if (ev && bus.resp_ready) begin
                    void'(q.pop_front());
                    busy = 1'b0;
                end
            end else if (eg != 2'b00) begin
                e = eg[1] ? ref_add(1'b1, bus.req1_a, bus.req1_b, bus.req1_cin)
                          : ref_add(1'b0, bus.req0_a, bus.req0_b, bus.req0_cin);
                q.push_back(e);
                busy    = 1'b1;
                acc_cyc = cyc;
                last    = eg[1];
            end
        end
    end

    task automatic issue(input logic port, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
        logic got;
        got = 1'b0;
        if (port) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_valid = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = port ? bus.req1_ready : bus.req0_ready;
        end
        chk("accept_to", 64'(got), 64'd1);
        @(posedge clk); #1;
        if (port) bus.req1_valid = 1'b0;
        else      bus.req0_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic id, input logic [WIDTH-1:0] s,
                             input logic co, input logic ov);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.resp_valid;
        end
        chk({tag, "_to"},   64'(got),           64'd1);
        chk({tag, "_sum"},  64'(bus.resp_sum),  64'(s));
        chk({tag, "_cout"}, 64'(bus.resp_cout), 64'(co));
        chk({tag, "_ovf"},  64'(bus.resp_ovf),  64'(ov));
        chk({tag, "_id"},   64'(bus.resp_id),   64'(id));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        logic g;
        int   gseq[4];
        int   seen;

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.resp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(1'b0, 32'h0000_000F, 32'h0000_0001, 1'b0);
        wait_resp("basic", 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_resp("ripple", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_resp("ovf_pos", 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_resp("ovf_neg", 1'b1, 32'h0000_0000, 1'b1, 1'b1);

        // Fairness with both requesters continuously valid.
        bus.req0_a = pick(); bus.req0_b = pick(); bus.req0_cin = 1'($urandom_range(0, 1));
        bus.req1_a = pick(); bus.req1_b = pick(); bus.req1_cin = 1'($urandom_range(0, 1));
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            g   = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (bus.req0_ready) begin got = 1'b1; g = 1'b0; end
                else if (bus.req1_ready) begin got = 1'b1; g = 1'b1; end
            end
            chk("fair_to", 64'(got), 64'd1);
            gseq[n] = int'(g);
            @(posedge clk); #1;
            if (g) begin bus.req1_a = pick(); bus.req1_b = pick(); end
            else   begin bus.req0_a = pick(); bus.req0_b = pick(); end
            if (n == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        for (int n = 0; n < 4; n++) chk("fair_seq", 64'(gseq[n]), 64'(n % 2));
        repeat (12) @(posedge clk);
        #1;

        // Backpressure: result must hold while the consumer stalls.
        bus.resp_ready = 1'b0;
        issue(1'b0, 32'h0000_0005, 32'h0000_0003, 1'b1);
        bus.req1_a = 32'h1; bus.req1_b = 32'h1; bus.req1_cin = 1'b0; bus.req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.resp_valid;
        end
        chk("bp_to", 64'(got), 64'd1);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("bp_valid", 64'(bus.resp_valid), 64'd1);
            chk("bp_sum",   64'(bus.resp_sum),   64'h9);
            chk("bp_flags", 64'({bus.resp_id, bus.resp_cout, bus.resp_ovf}), 64'd0);
            chk("bp_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next", 64'(bus.req1_ready), 64'd1);
        @(posedge clk); #1 bus.req1_valid = 1'b0;
        wait_resp("bp_r1", 1'b1, 32'h0000_0002, 1'b0, 1'b0);

        // Reset while the fourth slice is being processed.
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 64'(bus.resp_valid), 64'd0);
        chk("mrst_sum",   64'(bus.resp_sum),   64'd0);
        chk("mrst_flags", 64'({bus.resp_id, bus.resp_cout, bus.resp_ovf}), 64'd0);
        chk("mrst_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        chk("mrst_noresp", 64'(seen), 64'd0);
        @(posedge clk); #1;
        issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_resp("post_rst", 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Randomized traffic: flickering valids, stalls, one reset.
        for (int i = 0; i < 600; i++) begin
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req0_a = pick(); bus.req0_b = pick(); bus.req0_cin = 1'($urandom_range(0, 1));
            bus.req1_a = pick(); bus.req1_b = pick(); bus.req1_cin = 1'($urandom_range(0, 1));
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            rst = (i == 333);
            @(posedge clk); #1;
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
